// File: rtl/beamformer_pkg.sv
// Shared definitions for the beamformer input path: widths, slice encoding
// and the write-side packer state type.
package beamformer_pkg;

  localparam int SAMPLE_W = 12;
  localparam int SLOT_W   = 31;
  localparam int SLICES   = 3;
  localparam int ADDR_W   = 11;
  localparam int WORD_W   = SLICES * SLOT_W;
  localparam int LEN_W    = 12;
  localparam int MAX_LEN  = 1 << ADDR_W;

  // Same numbering is used by the read-side slicing logic, keep it stable.
  typedef enum logic [1:0] {
    SLICE_IDLE = 2'd0,
    SLICE_1    = 2'd1,
    SLICE_2    = 2'd2,
    SLICE_3    = 2'd3
  } slice_t;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'd0,
    PK_FILL  = 2'd1,
    PK_WRITE = 2'd2,
    PK_DONE  = 2'd3
  } packer_state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return len;
  endfunction

endpackage

// File: rtl/bram_sample_packer_if.sv
// Sample stream in and RAM write port out of the packer, bundled together.
interface bram_sample_packer_if;
  import beamformer_pkg::*;

  logic [SAMPLE_W-1:0] in_sample;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   wr_address;
  logic [WORD_W-1:0]   wr_data;
  logic                wr_en;

  modport slave (
    input  in_sample,
    input  in_valid,
    output in_ready,
    output wr_address,
    output wr_data,
    output wr_en
  );

  modport master (
    output in_sample,
    output in_valid,
    input  in_ready,
    input  wr_address,
    input  wr_data,
    input  wr_en
  );

endinterface

// File: rtl/bram_sample_packer_slot_packer.sv
// Three zero-extended slot registers forming one RAM word, slot 1 in the
// least significant position.
module slot_packer
  import beamformer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  slice_t              sel,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [WORD_W-1:0]   word
);

  logic [SLOT_W-1:0] slot_q [SLICES];
  logic [SLOT_W-1:0] sample_ext;

  assign sample_ext = {{(SLOT_W-SAMPLE_W){1'b0}}, sample};

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int k = 0; k < SLICES; k++) begin
        slot_q[k] <= '0;
      end
    end else if (load) begin
      case (sel)
        SLICE_1: slot_q[0] <= sample_ext;
        SLICE_2: slot_q[1] <= sample_ext;
        SLICE_3: slot_q[2] <= sample_ext;
        default: ;
      endcase
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < SLICES; k++) begin
      word[k*SLOT_W +: SLOT_W] = slot_q[k];
    end
  end

endmodule

// File: rtl/bram_sample_packer.sv
// Write-side front end of the beamformer signal RAM: packs sample triples
// into 93-bit words and writes a frame of them to consecutive addresses.
module bram_sample_packer
  import beamformer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture_start,
  input  logic [LEN_W-1:0]   frame_len,
  bram_sample_packer_if.slave bus,
  output logic               busy,
  output logic               frame_done,
  output logic [LEN_W-1:0]   words_written
);

  packer_state_t     state_q, state_d;
  slice_t            slot_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  words_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] word;

  logic in_ready;
  logic wr_en;
  logic done;
  logic frame_start;
  logic accept;
  logic last_word;

  assign accept    = bus.in_valid && in_ready;
  assign last_word = (words_q + LEN_W'(1)) == len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      PK_IDLE: begin
        if (capture_start && frame_len != '0) begin
          frame_start = 1'b1;
          state_d     = PK_FILL;
        end
      end
      PK_FILL: begin
        in_ready = 1'b1;
        if (accept && slot_q == SLICE_3) begin
          state_d = PK_WRITE;
        end
      end
      PK_WRITE: begin
        wr_en   = 1'b1;
        state_d = last_word ? PK_DONE : PK_FILL;
      end
      PK_DONE: begin
        done    = 1'b1;
        state_d = PK_IDLE;
      end
      default: state_d = PK_IDLE;
    endcase
  end

  // Address saturates at the top of the RAM so a full-depth frame never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      slot_q  <= SLICE_IDLE;
    end else if (frame_start) begin
      len_q   <= clamp_len(frame_len);
      words_q <= '0;
      addr_q  <= '0;
      slot_q  <= SLICE_1;
    end else if (state_q == PK_FILL && accept) begin
      case (slot_q)
        SLICE_1: slot_q <= SLICE_2;
        SLICE_2: slot_q <= SLICE_3;
        default: slot_q <= SLICE_IDLE;
      endcase
    end else if (state_q == PK_WRITE) begin
      words_q <= words_q + LEN_W'(1);
      if (addr_q != {ADDR_W{1'b1}}) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      slot_q <= last_word ? SLICE_IDLE : SLICE_1;
    end
  end

  slot_packer u_slot_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (frame_start),
    .load   (state_q == PK_FILL && accept),
    .sel    (slot_q),
    .sample (bus.in_sample),
    .word   (word)
  );

  assign bus.in_ready   = in_ready;
  assign bus.wr_en      = wr_en;
  assign bus.wr_address = addr_q;
  assign bus.wr_data    = word;
  assign busy           = state_q != PK_IDLE;
  assign frame_done     = done;
  assign words_written  = words_q;

endmodule

// File: tb/tb_bram_sample_packer.sv
// Directed bench for bram_sample_packer: frames, gaps, edge lengths, ignored
// start, mid-word reset and zero-extension.
module tb_bram_sample_packer;
  import beamformer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             capture_start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             busy;
  logic             frame_done;
  logic [LEN_W-1:0] words_written;

  bram_sample_packer_if bus ();

  bram_sample_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture_start (capture_start),
    .frame_len     (frame_len),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt = 0;
  int stall_err = 0;
  int log_cnt = 0;
  int acc_cnt = 0;
  int partial_err = 0;
  int seq_err = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [WORD_W-1:0] last_data;
  logic [WORD_W-1:0] log_data [0:7];
  bit seen;

  function automatic logic [WORD_W-1:0] pack3(input logic [11:0] a, input logic [11:0] b,
                                              input logic [11:0] c);
    return {19'd0, c, 19'd0, b, 19'd0, a};
  endfunction

  // Write log: every write must follow exactly three accepted samples and
  // land on the next consecutive address.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (acc_cnt != 3 * (log_cnt + 1)) partial_err++;
      if (bus.wr_address != log_cnt[ADDR_W-1:0]) seq_err++;
      if (log_cnt < 8) log_data[log_cnt] = bus.wr_data;
      last_addr = bus.wr_address;
      last_data = bus.wr_data;
      log_cnt++;
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] s, input int gap);
    bit acc;
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 16) begin
      acc = bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) stall_err++;
  endtask

  task automatic startFrame(input logic [LEN_W-1:0] len);
    capture_start = 1'b1;
    frame_len     = len;
    tick();
    capture_start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (frame_done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clearLog();
    log_cnt = 0;
    acc_cnt = 0;
    partial_err = 0;
    seq_err = 0;
    done_cnt = 0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_wr_en", bus.wr_en, 1'b0);
    checkOutput("rst_wr_address", bus.wr_address, '0);
    checkOutput("rst_wr_data", bus.wr_data, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_words_written", words_written, '0);
    rst_n = 1'b1;
    tick();
    clearLog();

    $display("[TB] basic frame of two words");
    startFrame(12'd2);
    checkOutput("basic_busy_after_start", busy, 1'b1);
    checkOutput("basic_ready_after_start", bus.in_ready, 1'b1);
    applyStimulus(12'h001, 0);
    applyStimulus(12'h002, 0);
    applyStimulus(12'h003, 0);
    checkOutput("basic_w0_wr_en", bus.wr_en, 1'b1);
    checkOutput("basic_w0_ready_low", bus.in_ready, 1'b0);
    checkOutput("basic_w0_addr", bus.wr_address, 11'd0);
    checkOutput("basic_w0_data", bus.wr_data, pack3(12'h001, 12'h002, 12'h003));
    tick();
    checkOutput("basic_ready_back", bus.in_ready, 1'b1);
    checkOutput("basic_wr_en_single", bus.wr_en, 1'b0);
    applyStimulus(12'h004, 0);
    applyStimulus(12'h005, 0);
    applyStimulus(12'h006, 0);
    checkOutput("basic_w1_wr_en", bus.wr_en, 1'b1);
    checkOutput("basic_w1_addr", bus.wr_address, 11'd1);
    checkOutput("basic_w1_data", bus.wr_data, pack3(12'h004, 12'h005, 12'h006));
    tick();
    checkOutput("basic_frame_done", frame_done, 1'b1);
    checkOutput("basic_busy_in_done", busy, 1'b1);
    tick();
    checkOutput("basic_done_cleared", frame_done, 1'b0);
    checkOutput("basic_busy_cleared", busy, 1'b0);
    checkOutput("basic_words_written", words_written, 12'd2);
    checkOutput("basic_done_count", done_cnt, 1);
    checkOutput("basic_write_count", log_cnt, 2);

    $display("[TB] backpressure gaps across four words");
    clearLog();
    startFrame(12'd4);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(12'h100 + 12'(i), int'($urandom_range(0, 3)));
    end
    waitDone(50, seen);
    checkOutput("gap_done_seen", seen, 1'b1);
    tick();
    checkOutput("gap_write_count", log_cnt, 4);
    checkOutput("gap_partial_write", partial_err, 0);
    checkOutput("gap_addr_seq", seq_err, 0);
    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("gap_w%0d_data", w), log_data[w],
                  pack3(12'h100 + 12'(3*w), 12'h101 + 12'(3*w), 12'h102 + 12'(3*w)));
    end
    checkOutput("gap_words_written", words_written, 12'd4);

    $display("[TB] zero length start");
    clearLog();
    startFrame(12'd0);
    checkOutput("len0_busy", busy, 1'b0);
    checkOutput("len0_ready", bus.in_ready, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_sample = 12'h055;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    checkOutput("len0_no_write", log_cnt, 0);
    checkOutput("len0_no_accept", acc_cnt, 0);
    checkOutput("len0_words_kept", words_written, 12'd4);

    $display("[TB] capture_start during a frame");
    clearLog();
    startFrame(12'd3);
    for (int i = 0; i < 4; i++) applyStimulus(12'h200 + 12'(i), 0);
    capture_start = 1'b1;
    frame_len     = 12'd1;
    tick();
    capture_start = 1'b0;
    checkOutput("ign_busy", busy, 1'b1);
    checkOutput("ign_ready", bus.in_ready, 1'b1);
    for (int i = 4; i < 9; i++) applyStimulus(12'h200 + 12'(i), 0);
    waitDone(20, seen);
    checkOutput("ign_done_seen", seen, 1'b1);
    tick();
    checkOutput("ign_write_count", log_cnt, 3);
    checkOutput("ign_last_addr", last_addr, 11'd2);
    checkOutput("ign_addr_seq", seq_err, 0);
    checkOutput("ign_w1_data", log_data[1], pack3(12'h203, 12'h204, 12'h205));
    checkOutput("ign_words_written", words_written, 12'd3);

    $display("[TB] reset in the middle of a word");
    clearLog();
    startFrame(12'd1);
    applyStimulus(12'hAAA, 0);
    applyStimulus(12'hBBB, 0);
    rst_n         = 1'b0;
    capture_start = 1'b1;
    frame_len     = 12'd1;
    tick();
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_ready", bus.in_ready, 1'b0);
    checkOutput("rstmid_wr_en", bus.wr_en, 1'b0);
    checkOutput("rstmid_wr_data", bus.wr_data, '0);
    checkOutput("rstmid_words", words_written, '0);
    capture_start = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("rstmid_no_write", log_cnt, 0);
    clearLog();
    startFrame(12'd1);
    applyStimulus(12'h011, 0);
    applyStimulus(12'h022, 0);
    applyStimulus(12'h033, 0);
    checkOutput("rstmid_new_wr_en", bus.wr_en, 1'b1);
    checkOutput("rstmid_new_addr", bus.wr_address, 11'd0);
    checkOutput("rstmid_new_data", bus.wr_data, pack3(12'h011, 12'h022, 12'h033));
    waitDone(10, seen);
    checkOutput("rstmid_done_seen", seen, 1'b1);
    tick();

    $display("[TB] zero extension of full-scale samples");
    clearLog();
    startFrame(12'd1);
    for (int i = 0; i < 3; i++) applyStimulus(12'hFFF, 0);
    checkOutput("zext_data", bus.wr_data, {19'd0, 12'hFFF, 19'd0, 12'hFFF, 19'd0, 12'hFFF});
    checkOutput("zext_upper_zero", {bus.wr_data[92:74], bus.wr_data[61:43], bus.wr_data[30:12]}, '0);
    waitDone(10, seen);
    checkOutput("zext_done_seen", seen, 1'b1);
    tick();

    $display("[TB] oversized length clamps to full depth");
    clearLog();
    startFrame(12'hFFF);
    for (int i = 0; i < 3 * MAX_LEN; i++) applyStimulus(12'(i), 0);
    waitDone(20, seen);
    checkOutput("clamp_done_seen", seen, 1'b1);
    tick();
    checkOutput("clamp_write_count", log_cnt, 2048);
    checkOutput("clamp_last_addr", last_addr, 11'd2047);
    checkOutput("clamp_last_data", last_data, pack3(12'h7FD, 12'h7FE, 12'h7FF));
    checkOutput("clamp_addr_seq", seq_err, 0);
    checkOutput("clamp_partial_write", partial_err, 0);
    checkOutput("clamp_words_written", words_written, 12'd2048);
    checkOutput("clamp_done_count", done_cnt, 1);
    checkOutput("clamp_busy_end", busy, 1'b0);

    checkOutput("no_stalled_samples", stall_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/bram_sample_packer.md
# bram_sample_packer

Write-side front end for the beamformer input signal RAM. Accepts a stream of 12-bit channel samples in slice order (slice 1, slice 2, slice 3 for each sample index) and packs each group of three into one 93-bit word. It writes each word to consecutive addresses of the single-port input signal RAM. When a frame of `frame_len` words is complete it pulses `frame_done`, which arms the beamformer read-out through `startbeamformer`.

## Interface
Parameters:
- `SAMPLE_W`, 12: input sample width.
- `SLOT_W`, 31: width of one slice slot in a RAM word. Slot k (k=1..3) occupies bits [k*SLOT_W-1:(k-1)*SLOT_W].
- `SLICES`, 3: slots per word.
- `ADDR_W`, 11: RAM address width. Depth is 2^ADDR_W = 2048.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `capture_start`, in, 1: one-cycle pulse that begins a frame.
- `frame_len`, in, 12: number of words to write. It is sampled on `capture_start`.
- `in_sample`, in, `SAMPLE_W`: sample data.
- `in_valid`, in, 1: `in_sample` is valid.
- `in_ready`, out, 1: the packer accepts a sample this cycle.
- `wr_address`, out, `ADDR_W`: RAM write address.
- `wr_data`, out, `SLICES*SLOT_W` (93): packed word.
- `wr_en`, out, 1: RAM write strobe.
- `busy`, out, 1: a frame is in progress.
- `frame_done`, out, 1: one-cycle pulse after the last word is written.
- `words_written`, out, 12: count of words written in the current or last frame.

## Operation
- Transfer rule: a sample is accepted when `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready`=0.
    - `capture_start` with `frame_len` in 1..2048 → FILL. On entry: latch length, address←0, slot←1, `words_written`←0.
    - `frame_len` of 0 → start is ignored; stay in IDLE.
    - `frame_len` >2048 → clamped to 2048.
  - FILL: `in_ready`=1.
    - Each accepted sample is zero-extended to `SLOT_W` and placed in the current slot; slot then advances.
    - On acceptance in slot 3 → WRITE.
  - WRITE: `in_ready`=0.
    - `wr_en`=1 for exactly this cycle, with `wr_data` = {slot3, slot2, slot1} and `wr_address` = current address.
    - After the write: address+1 and `words_written`+1.
    - If `words_written`+1 == latched length → DONE; otherwise → FILL with slot←1.
  - DONE: `frame_done`=1 for one cycle, then → IDLE.
- `capture_start` while `busy` is ignored. No restart and no error is raised.
- The address never wraps. The maximum length of 2048 ends at address 2047.
- Slot registers are cleared to 0 when a new frame starts, so no stale data leaks into upper bits.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_address`=0, `wr_data`=0, `busy`=0, `frame_done`=0, `words_written`=0. State is IDLE.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. The partial word is discarded and no write is issued.
- `capture_start` at edge T: `busy`=1 and `in_ready`=1 from T+1.
- Third sample accepted at edge N:
  - `wr_en`=1 during cycle N+1.
  - `in_ready`=0 during cycle N+1.
  - `in_ready` returns at N+2 if the frame is not complete.
- Throughput: at most 3 samples per 4 cycles.
- Last write in cycle W: `frame_done`=1 in cycle W+1, and `busy`=0 from W+2.
- `in_valid` may drop at any point. The slot position is held indefinitely.
- Simultaneous `capture_start` and reset: reset wins.

## Structure
- Shared package `beamformer_pkg`:
  - `SAMPLE_W`, `SLOT_W`, `SLICES`, `ADDR_W`.
  - The slice state encoding (idle/slice1/slice2/slice3 = 0..3), shared with the read-side slicing logic.
  - The packer FSM state typedef.
- Sub-module `slot_packer`: three slot registers with a slot-select write and a clear. The top level keeps the FSM, address counter and length compare.

## Test plan
- Basic frame: reset, then `frame_len`=2 with samples 0x001..0x006 at full rate → two `wr_en` pulses:
  - address 0, data with slot1=0x001, slot2=0x002, slot3=0x003.
  - address 1, data with slots 0x004..0x006.
  - then `frame_done` once, `words_written`=2.
- Backpressure gaps: `in_valid` toggled randomly across a 4-word frame → same packed words as at full rate, and no write while a word is partial.
- Edge lengths:
  - `frame_len`=0 → no `busy`, no write.
  - `frame_len`=4095 → clamped; last write at address 2047, `words_written`=2048.
- Ignored start: `capture_start` pulsed mid-frame → frame continues unchanged and the address is not reset.
- Reset mid-word: reset after 2 samples of word 0 → no `wr_en`. A new frame then starts cleanly at address 0 with slot1 first.
- Zero-extension: sample 0xFFF in every slot → `wr_data` = 0x000000FFF in each 31-bit slot, with all bits above bit 11 of each slot equal to 0.
